// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    // Request captured at acceptance and held on the memory port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              instr;
        logic              wr;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              if_rsp_err;

    logic              d_rden;
    logic              d_wren;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_req_ready;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_rdata;
    logic              d_rsp_err;

    logic              mem_valid;
    logic              mem_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter view.
    modport master (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_rden, d_wren, d_addr, d_wdata, d_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output busy
    );

    // Requester/memory environment view.
    modport slave (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_rden, d_wren, d_addr, d_wdata, d_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// DATA-priority selection with a starvation guard for instruction fetch.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic sel_data_c,
    output logic grant_if_c,
    output logic grant_d_c
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    // DATA wins unless fetch has waited through LIMIT data grants.
    always_comb begin
        sel_data_c = d_req && !(if_req && (starve_cnt == LIMIT));
        grant_d_c  = idle && d_req && sel_data_c;
        grant_if_c = idle && if_req && !sel_data_c;
    end

    // Count data grants that overtook a pending fetch, saturating at LIMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if_c || (idle && !if_req)) begin
            starve_cnt <= '0;
        end else if (grant_d_c && if_req && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between fetch and load/store.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);

    localparam int unsigned    TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);
    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);

    state_t            state_q, state_n;
    owner_t            owner_q, owner_n;
    mem_req_t          req_q, req_n;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              accept, done_ok, done_tmo;
    logic [DATA_W-1:0] rsp_data_n;

    logic              idle, d_req;
    logic              sel_data_c, grant_if_c, grant_d_c;

    logic              mem_valid_q, busy_q;
    logic              if_rsp_valid_q, if_rsp_err_q, d_rsp_valid_q, d_rsp_err_q;
    logic [DATA_W-1:0] if_rsp_data_q, d_rsp_rdata_q;

    assign idle  = (state_q == ST_IDLE);
    assign d_req = bus.d_rden | bus.d_wren;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk        (clk),
        .rst        (rst),
        .idle       (idle),
        .if_req     (bus.if_req_valid),
        .d_req      (d_req),
        .sel_data_c (sel_data_c),
        .grant_if_c (grant_if_c),
        .grant_d_c  (grant_d_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            req_q   <= '0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            req_q   <= req_n;
        end
    end

    // Next state, request capture and completion qualifiers.
    always_comb begin
        state_n    = state_q;
        owner_n    = owner_q;
        req_n      = req_q;
        accept     = 1'b0;
        done_ok    = 1'b0;
        done_tmo   = 1'b0;
        rsp_data_n = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_d_c) begin
                    // A simultaneous read and write is issued as the write.
                    accept      = 1'b1;
                    state_n     = ST_BUSY;
                    owner_n     = OWN_DATA;
                    req_n.addr  = bus.d_addr;
                    req_n.wdata = bus.d_wren ? bus.d_wdata : '0;
                    req_n.wstrb = bus.d_wren ? bus.d_wstrb : '0;
                    req_n.instr = 1'b0;
                    req_n.wr    = bus.d_wren;
                end else if (grant_if_c) begin
                    accept      = 1'b1;
                    state_n     = ST_BUSY;
                    owner_n     = OWN_IF;
                    req_n.addr  = bus.if_req_addr;
                    req_n.wdata = '0;
                    req_n.wstrb = '0;
                    req_n.instr = 1'b1;
                    req_n.wr    = 1'b0;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    done_ok    = 1'b1;
                    state_n    = ST_RESP;
                    rsp_data_n = req_q.wr ? '0 : bus.mem_rdata;
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    done_tmo = 1'b1;
                    state_n  = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
                owner_n = OWN_NONE;
            end
            default: begin
                state_n = ST_IDLE;
                owner_n = OWN_NONE;
            end
        endcase
    end

    // Counts BUSY cycles since acceptance for the response timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Registered port status and one-cycle response pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_err_q    <= 1'b0;
            d_rsp_rdata_q  <= '0;
        end else begin
            mem_valid_q    <= (state_n == ST_BUSY);
            busy_q         <= (state_n != ST_IDLE);
            if_rsp_valid_q <= (done_ok | done_tmo) && (owner_q == OWN_IF);
            if_rsp_err_q   <= done_tmo && (owner_q == OWN_IF);
            if_rsp_data_q  <= (owner_q == OWN_IF) ? rsp_data_n : '0;
            d_rsp_valid_q  <= (done_ok | done_tmo) && (owner_q == OWN_DATA);
            d_rsp_err_q    <= done_tmo && (owner_q == OWN_DATA);
            d_rsp_rdata_q  <= (owner_q == OWN_DATA) ? rsp_data_n : '0;
        end
    end

    assign bus.if_req_ready = grant_if_c;
    assign bus.d_req_ready  = grant_d_c;
    assign bus.if_rsp_valid = if_rsp_valid_q;
    assign bus.if_rsp_data  = if_rsp_data_q;
    assign bus.if_rsp_err   = if_rsp_err_q;
    assign bus.d_rsp_valid  = d_rsp_valid_q;
    assign bus.d_rsp_rdata  = d_rsp_rdata_q;
    assign bus.d_rsp_err    = d_rsp_err_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.mem_instr    = req_q.instr;
    assign bus.mem_addr     = req_q.addr;
    assign bus.mem_wdata    = req_q.wdata;
    assign bus.mem_wstrb    = req_q.wstrb;
    assign bus.busy         = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF) and the execution stage's load/store path (DATA).
- One outstanding transaction at a time, picorv32-style valid/ready memory handshake.
- DATA has priority, with a starvation guard for IF and an optional response timeout.
- Sits between fetch/execution and the memory/bus wrapper.

Parameters:
- STARVE_LIMIT, 4, consecutive DATA grants allowed while IF is pending before IF is forced next (range 1..15).
- TIMEOUT_CYCLES, 0, number of mem_valid cycles without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  32  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  fetch aborted by timeout (qualifies if_rsp_valid)
- d_rden  in  1  load request
- d_wren  in  1  store request
- d_addr  in  32  load/store address
- d_wdata  in  32  store data, already lane-replicated
- d_wstrb  in  4  store byte strobes
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  one-cycle data response pulse (loads and stores)
- d_rsp_rdata  out  32  load data (0 for stores)
- d_rsp_err  out  1  data access aborted by timeout
- mem_valid  out  1  memory request
- mem_instr  out  1  request is an instruction fetch
- mem_addr  out  32  memory address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write strobes (0000 for reads)
- mem_ready  in  1  memory completes the transfer this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1
- busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset: state=IDLE; starvation count=0; timeout count=0; owner=NONE; all outputs 0.
- Reset asserted mid-transaction drops the transaction: no response pulse, mem_valid low immediately.
- FSM states:
  - IDLE: requests can be accepted.
  - BUSY: mem_valid=1, waiting for mem_ready.
  - RESP: one cycle; rsp pulse driven; returns to IDLE.
- Acceptance happens only in IDLE. Ready outputs are combinational:
  - d_req_ready = IDLE & (d_rden|d_wren) & sel_data.
  - if_req_ready = IDLE & if_req_valid & !sel_data.
- Selection (sel_data): DATA wins if it requests, unless IF is pending and starve_cnt == STARVE_LIMIT.
- Starvation counter:
  - Increments on each DATA grant while if_req_valid=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant or whenever if_req_valid=0 in IDLE.
- d_rden & d_wren both high: treated as a write; the read is ignored.
- On accept (edge T), register addr, wdata, wstrb (reads force 0000), mem_instr and owner; enter BUSY. mem_valid is high from T+1.
- mem_* outputs are held stable while BUSY. Requesters may change their inputs after acceptance.
- In BUSY, mem_valid & mem_ready at edge: capture mem_rdata (0 for stores) and go to RESP.
- RESP:
  - The owner's rsp_valid is 1 for exactly one cycle with registered data and err=0.
  - mem_valid=0.
  - Next state is IDLE.
- Minimum cost with a zero-wait memory is 3 cycles per transaction (accept, BUSY, RESP).
- mem_ready while not BUSY is ignored.
- Requester dropping valid before ready: allowed; nothing is captured.
- Timeout (TIMEOUT_CYCLES>0):
  - Counts BUSY cycles.
  - When the count reaches TIMEOUT_CYCLES with no mem_ready, go to RESP with err=1 and data 0.
  - mem_valid drops. A late mem_ready is ignored.
- busy=1 in BUSY and RESP.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - Owner encoding (OWN_NONE, OWN_IF, OWN_DATA).
  - Starvation counter width (4 bits).
- One sub-module, mem_arb_prio: combinational selection plus the starvation counter. Outputs sel_data and grant strobes.
- The FSM, capture registers and timeout counter live in the top module.

Test Plan:
- Read, zero-wait: d_rden=1, d_addr=0x100 in IDLE.
  - Expect d_req_ready=1.
  - Next cycle: mem_valid=1, mem_addr=0x100, mem_wstrb=0, mem_instr=0.
  - mem_ready=1 with rdata 0xDEADBEEF gives d_rsp_valid pulse with 0xDEADBEEF one cycle later.
- Store: d_wren=1, addr 0x204, wdata 0x11223344, wstrb 0100.
  - Expect mem_wstrb=0100 and mem_wdata=0x11223344 held across 3 wait cycles.
  - Expect d_rsp_valid pulse with rdata 0.
- Starvation: if_req_valid and d_rden held continuously, STARVE_LIMIT=4.
  - Grant order D,D,D,D,IF,D,...
  - mem_instr=1 only on the 5th transaction.
- Timeout: TIMEOUT_CYCLES=8, mem_ready held 0 after an IF request.
  - After 8 BUSY cycles, if_rsp_valid=1, if_rsp_err=1, data 0, mem_valid=0.
  - A later mem_ready produces no response.
- Reset mid-BUSY: assert rst asynchronously while mem_valid=1.
  - mem_valid=0 immediately; no rsp pulse; after release, a new request is accepted normally.
- Simultaneous d_rden & d_wren with wstrb 1111 → write issued (mem_wstrb=1111), single response.
